// File: rtl/data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl
//   Byte-addressed big-endian data memory behind a valid/ready request/response
//   handshake. It supports byte, halfword and word accesses, plus dword when
//   DATA_W=64. Loads are sign- or zero-extended. Misaligned accesses are detected,
//   and the access latency is programmable. Only one request can be outstanding.
//
//   Build option: define DMEM_UNALIGNED_EN to make misaligned accesses legal.
//   Each byte lane then wraps modulo DEPTH. Only an oversize request raises
//   rsp_err. When the macro is undefined, a misaligned access raises rsp_err
//   and does not write memory.
//
// Parameters
//   DATA_W    : word width, 32 or 64
//   ADDR_W    : byte address width, DEPTH = 2**ADDR_W bytes
//   LATENCY   : cycles from accept edge to rsp_valid, 1..15
//   INIT_FILE : name of the simulation preload image ("" = none); the storage
//               array has no reset and no preload path in hardware
//
// Ports
//   clk, rst_n            : rising-edge clock, asynchronous active-low reset
//   req_valid / req_ready : request handshake (ready only in IDLE, low in reset)
//   req_we, req_size      : store/load, access bytes = 1 << req_size
//   req_sign              : load sign-extension select
//   req_addr, req_wdata   : byte address, right-justified store data
//   rsp_valid / rsp_ready : response handshake
//   rsp_rdata, rsp_err    : extended load data (0 on stores/errors), error flag
// -----------------------------------------------------------------------------
module data_mem_ctrl #(
   parameter int    DATA_W    = 32,
   parameter int    ADDR_W    = 5,
   parameter int    LATENCY   = 1,
   parameter string INIT_FILE = "data/data_memory.dat"
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_sign,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err
);

   localparam int         BYTES    = DATA_W / 8;
   localparam int         DEPTH    = 1 << ADDR_W;
   localparam logic [3:0] BYTES_W  = 4'(BYTES);
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic                rsp_err_q, rsp_err_d;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

   logic [7:0]          mem_q [DEPTH];

   logic                accept_s;
   logic [3:0]          size_bytes_s;
   logic                size_err_s;
   logic                acc_err_s;
   logic                fill_s;
   logic [DATA_W-1:0]   load_data_s;
   logic [ADDR_W-1:0]   lane_addr_s [BYTES];
   logic [BYTES-1:0]    wr_en_d;
   logic [7:0]          wr_byte_d [BYTES];

   // The image name is only meaningful to simulation tooling. Hardware storage always powers up undefined.
   if (INIT_FILE == "") begin : g_no_image
   end else begin : g_image
   end

   assign req_ready    = rst_n & (state_q == ST_IDLE);
   assign accept_s     = req_valid & req_ready;
   assign size_bytes_s = 4'd1 << req_size;
   assign size_err_s   = (size_bytes_s > BYTES_W);

`ifdef DMEM_UNALIGNED_EN
   assign acc_err_s = size_err_s;
`else
   logic misalign_s;
   // Any address bit below the access size makes the request misaligned.
   assign misalign_s = |(req_addr & ADDR_W'(size_bytes_s - 4'd1));
   assign acc_err_s  = size_err_s | misalign_s;
`endif

   // Lane mapping: result byte j (0 = LSB) lives at addr + size_bytes-1-j. The lowest address holds the MSB.
   always_comb begin
      fill_s      = req_sign & mem_q[req_addr][7];
      load_data_s = {DATA_W{1'b0}};
      for (int j = 0; j < BYTES; j++) begin
         lane_addr_s[j] = req_addr + ADDR_W'(size_bytes_s - 4'd1 - 4'(j));
         if (4'(j) < size_bytes_s) begin
            load_data_s[j*8 +: 8] = mem_q[lane_addr_s[j]];
         end else begin
            load_data_s[j*8 +: 8] = {8{fill_s}};
         end
      end
   end

   // Store byte enables and data. They fire only on the accept edge of a legal store.
   always_comb begin
      for (int j = 0; j < BYTES; j++) begin
         wr_en_d[j]   = accept_s & req_we & ~acc_err_s & (4'(j) < size_bytes_s);
         wr_byte_d[j] = req_wdata[j*8 +: 8];
      end
   end

   // Storage array. It has no reset, so stores survive a later rst_n pulse.
   always_ff @(posedge clk) begin
      for (int j = 0; j < BYTES; j++) begin
         if (wr_en_d[j]) begin
            mem_q[lane_addr_s[j]] <= wr_byte_d[j];
         end
      end
   end

   // Next-state and response logic for the IDLE -> WAIT -> RESP sequence.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rsp_valid_d = rsp_valid_q;
      rsp_err_d   = rsp_err_q;
      rsp_rdata_d = rsp_rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               rsp_err_d   = acc_err_s;
               rsp_rdata_d = (req_we | acc_err_s) ? {DATA_W{1'b0}} : load_data_s;
               cnt_d       = CNT_INIT;
               if (LATENCY == 1) begin
                  state_d     = ST_RESP;
                  rsp_valid_d = 1'b1;
               end else begin
                  state_d     = ST_WAIT;
                  rsp_valid_d = 1'b0;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            // The counter reaches 0 on the same edge that enters RESP.
            // The "<=" also recovers from a corrupted zero count.
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               state_d     = ST_RESP;
               rsp_valid_d = 1'b1;
               cnt_d       = 4'd0;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d     = ST_IDLE;
               rsp_valid_d = 1'b0;
            end else begin
               state_d = ST_RESP;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            cnt_d       = 4'd0;
            rsp_valid_d = 1'b0;
         end
      endcase
   end

   // Control and response registers. An asynchronous reset discards any pending response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 4'd0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= {DATA_W{1'b0}};
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;

endmodule
